// File: rtl/line_fill_responder.sv
// ============================================================================
// Module      : line_fill_responder
// Description : Memory-side responder for cache line refills and writebacks.
//               Accepts one line request at a time and models access latency
//               against a line-addressed backing store. The response goes out
//               on a valid/ready channel.
//               Optional build macro LINE_FILL_STATS_EN adds saturating
//               read/write response counters (stat_reads, stat_writes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_fill_responder #(
  parameter int ADDR_WIDTH    = 32,
  parameter int LINE_BITS     = 512,
  parameter int DEPTH_LINES   = 1024,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_BITS-1:0]  req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_write,
  output logic [LINE_BITS-1:0]  resp_rdata,
  output logic                  busy
`ifdef LINE_FILL_STATS_EN
  ,
  output logic [31:0]           stat_reads,
  output logic [31:0]           stat_writes
`endif
);

  localparam int c_idx_w   = $clog2(DEPTH_LINES);
  localparam int c_max_lat = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int c_cnt_w   = $clog2(c_max_lat) + 1;

  // Counter is loaded with latency-1 so the response lands exactly L edges
  // after acceptance (one edge per WAIT count, plus the edge that leaves WAIT).
  localparam logic [c_cnt_w-1:0] c_rd_load = c_cnt_w'(READ_LATENCY - 1);
  localparam logic [c_cnt_w-1:0] c_wr_load = c_cnt_w'(WRITE_LATENCY - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic [c_cnt_w-1:0]    r_cnt;
  logic                  r_write;
  logic [c_idx_w-1:0]    r_idx;
  logic [LINE_BITS-1:0]  r_wdata;
  logic [LINE_BITS-1:0]  r_mem [DEPTH_LINES];

  logic                  w_accept;
  logic                  w_done;
  logic                  w_commit;
  logic [c_idx_w-1:0]    w_req_idx;

  // Offset bits and index bits above the store depth are don't-care (wrap).
  assign w_req_idx = req_addr[6 +: c_idx_w];

  generate
    if (ADDR_WIDTH > 6 + c_idx_w) begin : g_addr_hi
      logic w_unused_addr;
      assign w_unused_addr = ^{req_addr[5:0], req_addr[ADDR_WIDTH-1:6+c_idx_w]};
    end else begin : g_addr_nohi
      logic w_unused_addr;
      assign w_unused_addr = ^req_addr[5:0];
    end
  endgenerate

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_done    = (r_state == ST_WAIT) && (r_cnt == '0);
  // Reset forces IDLE asynchronously, so an aborted write never reaches commit.
  assign w_commit  = w_done && r_write;

  // Request/response FSM with registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_write    <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      resp_valid <= 1'b0;
      resp_write <= 1'b0;
      resp_rdata <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_write <= req_write;
            r_idx   <= w_req_idx;
            r_wdata <= req_wdata;
            r_cnt   <= req_write ? c_wr_load : c_rd_load;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            resp_rdata <= r_write ? r_wdata : r_mem[r_idx];
            resp_write <= r_write;
            resp_valid <= 1'b1;
            r_state    <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - c_cnt_one;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Backing store write port; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

`ifdef LINE_FILL_STATS_EN
  logic w_resp_hs;
  assign w_resp_hs = resp_valid && resp_ready;

  // Saturating per-type response handshake counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_reads  <= '0;
      stat_writes <= '0;
    end else if (w_resp_hs) begin
      if (resp_write) begin
        if (stat_writes != 32'hFFFF_FFFF) stat_writes <= stat_writes + 32'd1;
      end else begin
        if (stat_reads != 32'hFFFF_FFFF) stat_reads <= stat_reads + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_line_fill_responder.sv
// ============================================================================
// Module      : tb_line_fill_responder
// Description : Self-checking bench for line_fill_responder: a table of
//               directed requests plus hand-written back-pressure and
//               mid-operation reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_fill_responder;

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [31:0]  req_addr;
  logic [511:0] req_wdata;
  logic         resp_valid;
  logic         resp_ready;
  logic         resp_write;
  logic [511:0] resp_rdata;
  logic         busy;
`ifdef LINE_FILL_STATS_EN
  logic [31:0]  stat_reads;
  logic [31:0]  stat_writes;
`endif

  int checks   = 0;
  int failures = 0;

  line_fill_responder dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_write (resp_write),
    .resp_rdata (resp_rdata),
    .busy       (busy)
`ifdef LINE_FILL_STATS_EN
    ,
    .stat_reads (stat_reads),
    .stat_writes(stat_writes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [511:0] wdata;
    int           exp_lat;
    logic [511:0] exp_rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at the negedge right after the acceptance edge; counts edges until
  // resp_valid is first seen (bounded).
  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_req(input logic wr, input logic [31:0] addr, input logic [511:0] wd,
                         output int lat, output logic [511:0] rd, output logic rw);
    int n;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wd;
    resp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    // Changes after acceptance must have no effect.
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = '0;
    wait_resp(lat);
    rd = resp_rdata;
    rw = resp_write;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [511:0] line_a, line_b, line_c, line_d, line_p, line_x;
  logic [511:0] got_rd;
  logic         got_rw;
  int           got_lat;

  initial begin
    line_a = {16{32'hA5A5_0001}};
    line_b = {16{32'h1234_5678}};
    line_c = {16{32'hC0DE_0003}};
    line_d = {16{32'h0F0F_F0F0}};
    line_p = {16{32'h5555_AAAA}};
    line_x = {16{32'hDEAD_BEEF}};

    vecs[0]  = '{1'b1, 32'h0000_0040, line_a, 2, line_a};
    vecs[1]  = '{1'b0, 32'h0000_0040, line_x, 4, line_a};
    vecs[2]  = '{1'b0, 32'h0001_0040, line_x, 4, line_a};
    vecs[3]  = '{1'b0, 32'h0000_007C, line_x, 4, line_a};
    vecs[4]  = '{1'b1, 32'h0000_1000, line_b, 2, line_b};
    vecs[5]  = '{1'b0, 32'h0000_1000, line_x, 4, line_b};
    vecs[6]  = '{1'b1, 32'h0000_0040, line_c, 2, line_c};
    vecs[7]  = '{1'b0, 32'h0000_0040, line_x, 4, line_c};
    vecs[8]  = '{1'b1, 32'h0000_FFC0, line_d, 2, line_d};
    vecs[9]  = '{1'b0, 32'h0004_FFC0, line_x, 4, line_d};
    vecs[10] = '{1'b1, 32'h0000_0080, line_p, 2, line_p};
    vecs[11] = '{1'b0, 32'h0000_0080, line_x, 4, line_p};

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", 512'(resp_valid), 512'(0));
    chk("rst_busy",       512'(busy),       512'(0));
    chk("rst_req_ready",  512'(req_ready),  512'(1));
    chk("rst_resp_write", 512'(resp_write), 512'(0));
    chk("rst_resp_rdata", resp_rdata,       '0);
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      run_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, got_lat, got_rd, got_rw);
      chk($sformatf("vec%0d_latency", i), 512'(got_lat), 512'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_resp_write", i), 512'(got_rw), 512'(vecs[i].wr));
      chk($sformatf("vec%0d_resp_rdata", i), got_rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_busy_after", i), 512'(busy), 512'(0));
    end

    // Back-pressure: read 0x40 (holds line_c), resp_ready low, a second
    // request to 0x1000 held pending throughout.
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 32'h0000_0040;
    req_wdata  = line_x;
    resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h0000_1000;
    wait_resp(got_lat);
    chk("bp_latency", 512'(got_lat), 512'(4));
    chk("bp_rdata",   resp_rdata, line_c);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp_hold_valid%0d", k), 512'(resp_valid), 512'(1));
      chk($sformatf("bp_hold_rdata%0d", k), resp_rdata, line_c);
      chk($sformatf("bp_hold_ready%0d", k), 512'(req_ready), 512'(0));
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_after_hs_valid", 512'(resp_valid), 512'(0));
    chk("bp_after_hs_ready", 512'(req_ready),  512'(1));
    chk("bp_after_hs_rdata", resp_rdata, line_c);
    @(posedge clk);
    @(negedge clk);
    chk("bp_second_accept_busy", 512'(busy), 512'(1));
    req_valid = 1'b0;
    wait_resp(got_lat);
    chk("bp_second_latency", 512'(got_lat), 512'(4));
    chk("bp_second_rdata",   resp_rdata, line_b);
    @(posedge clk);
    @(negedge clk);

    // Reset during a write's WAIT: 0x80 holds line_p; write line_x then abort.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0080;
    req_wdata = line_x;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_busy_before", 512'(busy), 512'(1));
    reset = 1'b1;
    #1;
    chk("abort_rst_valid", 512'(resp_valid), 512'(0));
    chk("abort_rst_busy",  512'(busy),       512'(0));
    chk("abort_rst_write", 512'(resp_write), 512'(0));
    chk("abort_rst_rdata", resp_rdata,       '0);
    repeat (2) @(negedge clk);
    chk("abort_rst_hold_valid", 512'(resp_valid), 512'(0));
    chk("abort_rst_hold_busy",  512'(busy),       512'(0));
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_no_resp", 512'(resp_valid), 512'(0));
    run_req(1'b0, 32'h0000_0080, line_x, got_lat, got_rd, got_rw);
    chk("abort_read_latency", 512'(got_lat), 512'(4));
    chk("abort_read_rdata",   got_rd, line_p);

`ifdef LINE_FILL_STATS_EN
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("stat_reads_rst0",  512'(stat_reads),  512'(0));
    chk("stat_writes_rst0", 512'(stat_writes), 512'(0));
    run_req(1'b0, 32'h0000_0040, line_x, got_lat, got_rd, got_rw);
    run_req(1'b1, 32'h0000_0100, line_a, got_lat, got_rd, got_rw);
    run_req(1'b0, 32'h0000_1000, line_x, got_lat, got_rd, got_rw);
    run_req(1'b1, 32'h0000_0140, line_b, got_lat, got_rd, got_rw);
    run_req(1'b0, 32'h0000_0100, line_x, got_lat, got_rd, got_rw);
    chk("stat_reads",  512'(stat_reads),  512'(3));
    chk("stat_writes", 512'(stat_writes), 512'(2));
    reset = 1'b1;
    @(negedge clk);
    chk("stat_reads_rst",  512'(stat_reads),  512'(0));
    chk("stat_writes_rst", 512'(stat_writes), 512'(0));
    reset = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/line_fill_responder.md
Name: line_fill_responder

Overview:
- Memory-side responder that serves the cache's line-fill and writeback traffic.
- Accepts one 512-bit line request at a time: a read (refill) or a write (writeback).
- Models main-memory access latency against an internal line-addressed backing store.
- Returns the full line, or a write acknowledgement, over a valid/ready response channel; the response line feeds the cache's mem_data_in fill path.

Parameters:
- ADDR_WIDTH, 32, byte-address width of req_addr.
- LINE_BITS, 512, line width in bits (64-byte lines, offset = addr[5:0]).
- DEPTH_LINES, 1024, number of lines in the backing store; power of two.
- READ_LATENCY, 4, cycles from request acceptance to resp_valid for reads; must be >= 1.
- WRITE_LATENCY, 2, cycles from request acceptance to resp_valid for writes; must be >= 1.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = writeback line, 0 = refill read.
- req_addr  input  ADDR_WIDTH  byte address; line index = req_addr[6 +: log2(DEPTH_LINES)].
- req_wdata  input  LINE_BITS  writeback line data.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts response.
- resp_write  output  1  echo of the request type.
- resp_rdata  output  LINE_BITS  read line (reads) or the written line (writes).
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, active-high): state=IDLE, counter=0, resp_valid=0, resp_write=0, resp_rdata=0, busy=0, latched request fields=0.
  - Backing store contents are not reset.
  - Reads of never-written lines return unspecified data.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at a rising edge, latch req_write, line index and req_wdata.
  - Load counter with (req_write ? WRITE_LATENCY : READ_LATENCY) - 1; go to WAIT.
- WAIT:
  - req_ready=0. Counter decrements each cycle.
  - On the edge where counter==0:
    - Write: commit the latched line to the store and set resp_rdata = latched data.
    - Read: set resp_rdata = store[index].
    - Set resp_write = latched type and resp_valid=1; go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_write held stable until resp_valid&&resp_ready.
  - On that handshake edge: resp_valid=0; go to IDLE. resp_rdata holds its last value.
- Latency: resp_valid first visible exactly L cycles after the acceptance edge (L = read or write latency). Back-pressure on resp_ready extends RESP indefinitely.
- Exactly one outstanding request.
  - req_ready is 0 in WAIT and RESP, so a new request can be accepted no earlier than the cycle after the response handshake.
  - Requests asserted while not ready are neither lost nor latched; the requester must hold them.
- Address wrap: index bits above log2(DEPTH_LINES)+6 and offset bits [5:0] are ignored.
- Read after write to the same line returns the newly written data. The write commit precedes any later read, because requests are serialized.
- Reset mid-operation: abort immediately.
  - A write still in WAIT is not committed.
  - A write already committed stays committed.
  - No response is issued for the aborted request.
- req_wdata is ignored for reads. req_addr/req_wdata changes after acceptance have no effect.

Optional Feature:
- Macro: LINE_FILL_STATS_EN.
- Defined:
  - Adds output ports stat_reads (32) and stat_writes (32), reset to 0.
  - The matching counter increments on each response handshake (resp_valid&&resp_ready) by resp_write type.
  - Counters saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then write line 0x0000_0040 with data = {16{32'hA5A5_0001}}, resp_ready=1 -> resp_valid high exactly 2 cycles after acceptance, resp_write=1, resp_rdata = written data, busy low the cycle after.
- Read 0x0000_0040 -> resp_valid exactly 4 cycles after acceptance, resp_write=0, resp_rdata={16{32'hA5A5_0001}}.
- Read 0x0001_0040 with DEPTH_LINES=1024 (wraps to index 1) -> returns the same line as 0x0000_0040. Offset 0x3C in the address also returns the same line.
- Read with resp_ready=0 for 10 cycles -> resp_valid and resp_rdata stable throughout. req_valid held high in this period -> req_ready=0, no second acceptance. Release resp_ready -> handshake, then the held request is accepted the next cycle.
- Write 0x80 with data X, assert reset during WAIT, then read 0x80 -> all outputs at reset values while reset is high, and the read does not return X (no commit).
- With LINE_FILL_STATS_EN: 3 reads + 2 writes -> stat_reads=3, stat_writes=2. Reset -> both counters 0.
